// File: rtl/instr_fetch.sv
// Instruction fetch front end.
// Owns the fetch PC and keeps at most one request open to instruction memory.
// Fetched words go into a 2-entry queue that feeds decode.
// Branch redirects flush the queue. A redirect that arrives while a request is
// still waiting on memory parks the target in DRAIN until that request retires.
// Fetch stops after a HLT opcode is enqueued.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OPC  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_instr,
  input  logic        imem_rdy,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_vld,
  input  logic        id_rdy,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  // Control state
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] target_q, target_d;
  logic        rd_en_q, rd_en_d;
  logic [1:0]  count_q, count_d;

  // Queue storage: head is what decode sees, tail is the second slot
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;

  // Handshake events for this cycle
  logic        done;
  logic        push;
  logic        pop;
  logic        is_hlt;
  logic        still_pending;
  entry_t      new_entry;

  // Decode this cycle's memory and decode-side handshakes
  always_comb begin
    done      = rd_en_q & imem_rdy;
    // Responses retiring in DRAIN, or alongside a redirect, are stale.
    push      = done & ~br_taken & (state_q == S_FETCH);
    pop       = (count_q != 2'd0) & id_rdy;
    is_hlt    = (imem_instr[15:12] == HLT_OPC);
    new_entry = '{pc: pc_q, instr: imem_instr};
    // A request that stays open into the next cycle must keep rd_en high.
    still_pending = rd_en_q & ~imem_rdy & (state_q == S_FETCH) & ~br_taken;
  end

  // Next state, fetch PC and saved redirect target
  always_comb begin
    // NOTE: every signal gets a default before the case so that paths that do
    // not mention it hold their value instead of inferring a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    unique case (state_q)
      S_FETCH: begin
        if (br_taken) begin
          if (rd_en_q && !imem_rdy) begin
            // Memory still owes us a word for the old address: wait it out.
            state_d  = S_DRAIN;
            target_d = br_target;
          end else begin
            pc_d = br_target;
          end
        end else if (push) begin
          pc_d = pc_q + 16'd1;
          if (is_hlt) state_d = S_HALT;
        end
      end
      S_DRAIN: begin
        if (done) begin
          state_d = S_FETCH;
          // A redirect landing on the retiring cycle wins over the saved one.
          pc_d    = br_taken ? br_target : target_q;
        end else if (br_taken) begin
          target_d = br_target;
        end
      end
      S_HALT: begin
        if (br_taken) begin
          state_d = S_FETCH;
          pc_d    = br_target;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Queue update: push, pop, both, or flush on redirect
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (br_taken) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Pop implies at least one entry, so the new word goes behind it.
          if (count_q == 2'd1) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Request enable for next cycle, registered so the memory sees a clean strobe
  always_comb begin
    unique case (state_d)
      S_DRAIN: rd_en_d = 1'b1;
      S_HALT:  rd_en_d = 1'b0;
      default: rd_en_d = still_pending | (count_d < 2'd2);
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      rd_en_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      rd_en_q  <= rd_en_d;
      count_q  <= count_d;
    end
  end

  // Queue payload registers
  always_ff @(posedge clk) begin
    // NOTE: payload slots carry no reset; count_q alone decides validity and
    // the outputs are masked while the queue is empty.
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Output drive
  always_comb begin
    imem_addr  = pc_q;
    imem_rd_en = rd_en_q;
    if_vld     = (count_q != 2'd0);
    if_instr   = if_vld ? head_q.instr : 16'h0000;
    if_pc      = if_vld ? head_q.pc    : 16'h0000;
    halted     = (state_q == S_HALT);
  end

endmodule
